// File: rtl/proc_pkg.sv
// Shared processor definitions: program-counter width, address type and the
// next-PC source selector used by the program counter.
package proc_pkg;

  localparam int PC_W = 10;

  typedef logic [PC_W-1:0] pc_t;

  typedef enum logic [1:0] {
    PC_HOLD,
    PC_ABS,
    PC_REL,
    PC_INC
  } pc_sel_e;

endpackage

// File: rtl/prog_ctr_next.sv
// Combinational next-PC selection: priority decode of hold / absolute jump /
// relative branch / increment, all arithmetic wrapping modulo 2^PC_W.
module prog_ctr_next #(
  parameter int PC_W = proc_pkg::PC_W
) (
  input  logic [PC_W-1:0] pc,
  input  logic            start,
  input  logic            branch_abs,
  input  logic            branch_rel,
  input  logic            decision,
  input  logic            alu_flag,
  input  logic [PC_W-1:0] target,
  output logic [PC_W-1:0] next_pc
);
  import proc_pkg::*;

  logic            rel_taken;
  logic [PC_W-1:0] rel_sum;
  logic [PC_W-1:0] inc_sum;
  pc_sel_e         sel;

  assign rel_taken = branch_rel & (decision | alu_flag);

  // Same-width two's-complement add equals a sign-extended add, truncated.
  assign rel_sum = pc + target;
  assign inc_sum = pc + PC_W'(1);

  always_comb begin
    sel = PC_INC;
    if (start)
      sel = PC_HOLD;
    else if (branch_abs)
      sel = PC_ABS;
    else if (rel_taken)
      sel = PC_REL;
  end

  always_comb begin
    next_pc = pc;
    case (sel)
      PC_HOLD: next_pc = pc;
      PC_ABS:  next_pc = target;
      PC_REL:  next_pc = rel_sum;
      PC_INC:  next_pc = inc_sum;
      default: next_pc = pc;
    endcase
  end

endmodule

// File: rtl/prog_ctr.sv
// Program counter: registered instruction-memory address with asynchronous
// active-low reset, next value chosen by prog_ctr_next.
module prog_ctr #(
  parameter int              PC_W       = proc_pkg::PC_W,
  parameter logic [PC_W-1:0] RESET_ADDR = '0
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic            BranchAbs,
  input  logic            BranchRel,
  input  logic            Decision,
  input  logic            ALU_flag,
  input  logic [PC_W-1:0] Target,
  output logic [PC_W-1:0] ProgCtr
);

  logic [PC_W-1:0] next_pc;

  prog_ctr_next #(
    .PC_W(PC_W)
  ) u_next (
    .pc        (ProgCtr),
    .start     (Start),
    .branch_abs(BranchAbs),
    .branch_rel(BranchRel),
    .decision  (Decision),
    .alu_flag  (ALU_flag),
    .target    (Target),
    .next_pc   (next_pc)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)
      ProgCtr <= RESET_ADDR;
    else
      ProgCtr <= next_pc;
  end

endmodule

// File: tb/tb_prog_ctr.sv
// Scoreboard bench for prog_ctr: directed and random stimulus push expected
// addresses from an arithmetic reference model; a monitor pops and compares.
module tb_prog_ctr;

  localparam int PC_W = 10;
  localparam int MOD  = 1 << PC_W;

  logic            Clk;
  logic            Reset;
  logic            Start;
  logic            BranchAbs;
  logic            BranchRel;
  logic            Decision;
  logic            ALU_flag;
  logic [PC_W-1:0] Target;
  logic [PC_W-1:0] ProgCtr;

  int checks = 0;
  int errors = 0;
  int model_pc = 0;
  int exp_q[$];

  prog_ctr #(
    .PC_W      (PC_W),
    .RESET_ADDR(10'd0)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Start    (Start),
    .BranchAbs(BranchAbs),
    .BranchRel(BranchRel),
    .Decision (Decision),
    .ALU_flag (ALU_flag),
    .Target   (Target),
    .ProgCtr  (ProgCtr)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: next address from the priority rules, in plain integers.
  function automatic int modelNext(input int pc, input bit st, input bit ab, input bit rl,
                                   input bit dc, input bit fl, input int tgt);
    int offset;
    if (st) return pc;
    if (ab) return tgt;
    if (rl && (dc || fl)) begin
      offset = (tgt >= MOD / 2) ? tgt - MOD : tgt;
      return ((pc + offset) % MOD + MOD) % MOD;
    end
    return (pc + 1) % MOD;
  endfunction

  task automatic driveAndPush(input bit st, input bit ab, input bit rl,
                              input bit dc, input bit fl, input int tgt);
    Start     = st;
    BranchAbs = ab;
    BranchRel = rl;
    Decision  = dc;
    ALU_flag  = fl;
    Target    = PC_W'(tgt);
    model_pc  = modelNext(model_pc, st, ab, rl, dc, fl, tgt);
    exp_q.push_back(model_pc);
  endtask

  task automatic applyStimulus(input bit st, input bit ab, input bit rl,
                               input bit dc, input bit fl, input int tgt);
    @(negedge Clk);
    driveAndPush(st, ab, rl, dc, fl, tgt);
  endtask

  task automatic randomInputs();
    Start     = 1'($urandom);
    BranchAbs = 1'($urandom);
    BranchRel = 1'($urandom);
    Decision  = 1'($urandom);
    ALU_flag  = 1'($urandom);
    Target    = PC_W'($urandom);
  endtask

  // Monitor: one registered result per rising edge, compared just after it.
  initial begin
    forever begin
      @(posedge Clk);
      #1;
      if (!Reset)
        checkOutput("reset_hold", int'(ProgCtr), 0);
      else if (exp_q.size() > 0)
        checkOutput("pc_next", int'(ProgCtr), exp_q.pop_front());
    end
  end

  initial begin
    Reset = 1'b0;
    randomInputs();
    #1;
    checkOutput("reset_initial", int'(ProgCtr), 0);

    repeat (5) begin
      @(negedge Clk);
      randomInputs();
    end

    // Release reset: sequential count 1, 2, 3.
    @(negedge Clk);
    Reset    = 1'b1;
    model_pc = 0;
    driveAndPush(0, 0, 0, 0, 0, $urandom_range(0, MOD - 1));
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Absolute jump, held, and with a competing relative request.
    applyStimulus(0, 1, 0, 0, 0, 20);
    applyStimulus(0, 1, 0, 0, 0, 20);
    applyStimulus(0, 1, 1, 1, 0, 20);

    // Relative branches forward and backward.
    applyStimulus(0, 0, 1, 1, 0, 5);
    applyStimulus(0, 0, 1, 1, 0, 5);
    applyStimulus(0, 1, 0, 0, 0, 20);
    applyStimulus(0, 0, 1, 1, 0, 10'h3FB);

    // Relative request qualified by ALU flag.
    applyStimulus(0, 1, 0, 0, 0, 20);
    applyStimulus(0, 0, 1, 0, 0, 4);
    applyStimulus(0, 0, 1, 0, 1, 4);

    // Start hold overrides a pending jump.
    applyStimulus(0, 1, 0, 0, 0, 7);
    applyStimulus(1, 1, 0, 0, 0, 99);
    applyStimulus(1, 0, 1, 1, 1, 3);
    applyStimulus(0, 1, 0, 0, 0, 99);

    // Wrap-around on increment and on negative offset.
    applyStimulus(0, 1, 0, 0, 0, 1023);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 2);
    applyStimulus(0, 0, 1, 1, 0, 10'h3FB);

    // Asynchronous reset pulse between edges, then count resumes from 0.
    @(negedge Clk);
    Reset = 1'b0;
    #1;
    checkOutput("async_reset", int'(ProgCtr), 0);
    #1;
    Reset    = 1'b1;
    model_pc = 0;
    driveAndPush(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 10'h155);

    // Random traffic with branch-heavy weighting.
    for (int i = 0; i < 300; i++) begin
      applyStimulus(($urandom % 8) == 0, ($urandom % 6) == 0, ($urandom % 3) == 0,
                    1'($urandom), 1'($urandom), int'($urandom_range(0, MOD - 1)));
    end

    // Drain the scoreboard within a bounded number of edges.
    @(negedge Clk);
    Start     = 1'b1;
    BranchAbs = 1'b0;
    BranchRel = 1'b0;
    for (int i = 0; i < 5 && exp_q.size() > 0; i++)
      @(negedge Clk);
    checkOutput("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
